// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope applied to an offset-binary oscillator stream.
// A 16-bit accumulator steps once per audio sample; its high byte scales the sample.
module envelope_adsr #(
    parameter int BITDEPTH = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic                gate,
    input  logic [7:0]          attack_rate,
    input  logic [7:0]          decay_rate,
    input  logic [7:0]          sustain_level,
    input  logic [7:0]          release_rate,
    input  logic [BITDEPTH-1:0] osc_in,
    output logic [BITDEPTH-1:0] out,
    output logic                out_valid,
    output logic                busy
);

    localparam logic [BITDEPTH-1:0] MIDPOINT = {1'b1, {(BITDEPTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_acc;
    logic [15:0]         w_acc_nxt;
    logic                r_gate_q;
    logic [BITDEPTH-1:0] r_out;
    logic                r_out_valid;
    logic                w_rise;
    logic                w_fall;
    logic [16:0]         w_att_sum;
    logic [16:0]         w_dec_diff;
    logic [16:0]         w_rel_diff;

    // Offset-binary sample times unsigned level; |p>>>8| stays below the midpoint, so no saturation.
    function automatic logic [BITDEPTH-1:0] f_scale(input logic [BITDEPTH-1:0] x,
                                                    input logic [7:0] lvl);
        logic signed [BITDEPTH+8:0] s;
        logic signed [BITDEPTH+8:0] l;
        logic signed [BITDEPTH+8:0] p;
        s = $signed({{9{~x[BITDEPTH-1]}}, ~x[BITDEPTH-1], x[BITDEPTH-2:0]});
        l = $signed({{(BITDEPTH+1){1'b0}}, lvl});
        p = s * l;
        return BITDEPTH'(p >>> 8) + MIDPOINT;
    endfunction

    assign w_rise     = gate & ~r_gate_q;
    assign w_fall     = ~gate & r_gate_q;
    // Bit 16 is the carry (attack) or borrow (decay/release) of the 12-bit step.
    assign w_att_sum  = {1'b0, r_acc} + {5'b0, attack_rate, 4'b0000};
    assign w_dec_diff = {1'b0, r_acc} - {5'b0, decay_rate, 4'b0000};
    assign w_rel_diff = {1'b0, r_acc} - {5'b0, release_rate, 4'b0000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_gate_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_gate_q <= gate;
        end
    end

    // A gate edge takes priority over the sample step; the accumulator is left untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        if (w_rise) begin
            w_state_nxt = S_ATTACK;
        end else if (w_fall) begin
            if (r_state == S_ATTACK || r_state == S_DECAY || r_state == S_SUSTAIN) begin
                w_state_nxt = S_RELEASE;
            end
        end else if (sample_en) begin
            case (r_state)
                S_ATTACK: begin
                    if (attack_rate == 8'h00 || w_att_sum[16]) begin
                        w_acc_nxt   = 16'hFFFF;
                        w_state_nxt = S_DECAY;
                    end else begin
                        w_acc_nxt = w_att_sum[15:0];
                    end
                end
                S_DECAY: begin
                    if (decay_rate == 8'h00 || w_dec_diff[16] ||
                        w_dec_diff[15:8] <= sustain_level) begin
                        w_acc_nxt   = {sustain_level, 8'h00};
                        w_state_nxt = S_SUSTAIN;
                    end else begin
                        w_acc_nxt = w_dec_diff[15:0];
                    end
                end
                S_SUSTAIN: begin
                    w_acc_nxt = {sustain_level, 8'h00};
                end
                S_RELEASE: begin
                    if (release_rate == 8'h00 || w_rel_diff[16] || w_rel_diff[15:0] == 16'h0000) begin
                        w_acc_nxt   = 16'h0000;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_acc_nxt = w_rel_diff[15:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output scaling uses the level held before this clock's accumulator step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= MIDPOINT;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= sample_en;
            if (sample_en) begin
                r_out <= f_scale(osc_in, r_acc[15:8]);
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_envelope_adsr.sv
// Bench for envelope_adsr: a vector table, hand-written corner sequences and a
// randomized run compared against an arithmetic model of the envelope.
module tb_envelope_adsr;

    localparam int BD = 12;
    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en;
    logic          gate;
    logic [7:0]    ar, dr, sl, rr;
    logic [BD-1:0] osc;
    logic [BD-1:0] out;
    logic          out_valid;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_ph, m_acc, m_out;
    bit m_gq, m_valid;

    typedef struct {
        logic          g;
        logic          se;
        logic [BD-1:0] o;
        logic [BD-1:0] e_out;
        logic          e_vld;
        logic          e_busy;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    envelope_adsr #(.BITDEPTH(BD)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_en     (sample_en),
        .gate          (gate),
        .attack_rate   (ar),
        .decay_rate    (dr),
        .sustain_level (sl),
        .release_rate  (rr),
        .osc_in        (osc),
        .out           (out),
        .out_valid     (out_valid),
        .busy          (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic g, input logic se, input logic [BD-1:0] o);
        gate      = g;
        sample_en = se;
        osc       = o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        gate      = 1'b0;
        sample_en = 1'b0;
        osc       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic int scale(input int o, input int lvl);
        int p;
        p = (o - 2048) * lvl;
        return ((p >>> 8) + 2048) & 4095;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_acc = 0; m_out = 2048; m_gq = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic g, input logic se, input int o);
        int  st;
        bit  rise, fall;
        rise = g && !m_gq;
        fall = !g && m_gq;
        m_gq = g;
        m_valid = se;
        if (se) m_out = scale(o, m_acc / 256);
        if (rise) begin
            m_ph = P_ATT;
        end else if (fall) begin
            if (m_ph == P_ATT || m_ph == P_DEC || m_ph == P_SUS) m_ph = P_REL;
        end else if (se) begin
            if (m_ph == P_ATT) begin
                st = int'(ar) * 16;
                if (ar == 0 || m_acc + st > 65535) begin m_acc = 65535; m_ph = P_DEC; end
                else m_acc = m_acc + st;
            end else if (m_ph == P_DEC) begin
                st = int'(dr) * 16;
                if (dr == 0 || m_acc - st < 0 || (m_acc - st) / 256 <= int'(sl)) begin
                    m_acc = int'(sl) * 256; m_ph = P_SUS;
                end else m_acc = m_acc - st;
            end else if (m_ph == P_SUS) begin
                m_acc = int'(sl) * 256;
            end else if (m_ph == P_REL) begin
                st = int'(rr) * 16;
                if (rr == 0 || m_acc - st <= 0) begin m_acc = 0; m_ph = P_IDLE; end
                else m_acc = m_acc - st;
            end
        end
    endtask

    initial begin
        logic          g, se;
        logic [BD-1:0] o;

        ar = 8'h00; dr = 8'h00; sl = 8'h80; rr = 8'h00;
        do_reset();
        check("reset_out", out, 12'h800);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);

        // Instant attack/decay to sustain 0x80, then instant release
        tbl[0] = '{1'b1, 1'b0, 12'hFFF, 12'h800, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 12'hFFF, 12'h800, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 12'hFFF, 12'hFF7, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 12'hFFF, 12'hFF7, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 12'h000, 12'h400, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 12'h000, 12'h400, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 12'hFFF, 12'hBFF, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 12'h123, 12'h800, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 12'h000, 12'h800, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].g, tbl[i].se, tbl[i].o);
            check($sformatf("tbl%0d_out", i), out, tbl[i].e_out);
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_vld);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end

        // Slow attack, decay to sustain, live sustain change, release and retrigger
        ar = 8'h10; dr = 8'h10; sl = 8'h80; rr = 8'h10;
        do_reset();
        step(1'b1, 1'b0, 12'hFFF);
        for (int k = 1; k <= 386; k++) begin
            if (k == 385) sl = 8'h40;
            step(1'b1, 1'b1, (k <= 258) ? 12'hFFF : 12'h000);
            if (k == 255) check("att_se255", out, 12'hFEF);
            if (k == 256) check("att_se256", out, 12'hFF7);
            if (k == 257) check("dec_se257", out, 12'hFF7);
            if (k == 258) check("dec_se258", out, 12'hFEF);
            if (k == 383) check("dec_se383", out, 12'h3F8);
            if (k == 384) check("sus_out", out, 12'h400);
            if (k == 385) check("sus_live_old", out, 12'h400);
            if (k == 386) check("sus_live_new", out, 12'h600);
            step(1'b1, 1'b0, 12'h000);
        end
        check("sus_busy", busy, 1);
        step(1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b1, 12'h000);
        check("rel_out", out, 12'h600);
        step(1'b0, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'h000);
        check("retrig_sim_out", out, 12'h608);
        check("retrig_sim_valid", out_valid, 1);
        check("retrig_sim_busy", busy, 1);
        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'h000);
        check("retrig_nostep", out, 12'h608);
        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'h000);
        check("retrig_climb", out, 12'h600);

        // Asynchronous reset mid-attack with gate held high across release
        ar = 8'h10;
        do_reset();
        step(1'b1, 1'b0, 12'hFFF);
        step(1'b1, 1'b1, 12'hFFF);
        step(1'b1, 1'b0, 12'hFFF);
        step(1'b1, 1'b1, 12'hFFF);
        check("pre_rst_out", out, 12'h807);
        rst = 1'b0;
        sample_en = 1'b0;
        #1;
        check("arst_out", out, 12'h800);
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        #1;
        rst = 1'b1;
        step(1'b1, 1'b0, 12'hFFF);
        check("post_rst_rise_busy", busy, 1);
        step(1'b1, 1'b1, 12'hFFF);
        check("post_rst_lvl0", out, 12'h800);
        step(1'b1, 1'b0, 12'hFFF);
        step(1'b1, 1'b1, 12'hFFF);
        check("post_rst_lvl1", out, 12'h807);

        // Randomized run against the reference model
        ar = 8'h40; dr = 8'h20; sl = 8'h60; rr = 8'h30;
        do_reset();
        model_reset();
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                ar = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                dr = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                rr = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 99) == 0) sl = 8'($urandom_range(0, 255));
            g  = ($urandom_range(0, 59) == 0) ? ~gate : gate;
            se = ($urandom_range(0, 1) == 0);
            o  = BD'($urandom_range(0, 4095));
            model_edge(g, se, int'(o));
            step(g, se, o);
            check($sformatf("rnd%0d_out", c), out, m_out);
            check($sformatf("rnd%0d_valid", c), out_valid, m_valid);
            check($sformatf("rnd%0d_busy", c), busy, (m_ph != P_IDLE) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
